// File: rtl/axi_lite_manager.sv
// AXI4-Lite manager: turns a single-beat command/response interface into
// AXI4-Lite read or write transactions, one outstanding at a time, and keeps
// a saturating count of SLVERR/DECERR responses.
module axi_lite_manager #(
    parameter int ABUS_SIZE = 5,
    parameter int DBUS_SIZE = 32,
    parameter int ECNT_SIZE = 8
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    // command side
    input  logic                 CMD_VALID,
    output logic                 CMD_READY,
    input  logic                 CMD_WRITE,
    input  logic [ABUS_SIZE-1:0] CMD_ADDR,
    input  logic [DBUS_SIZE-1:0] CMD_WDATA,
    // write address channel
    output logic [ABUS_SIZE-1:0] AWADDR,
    output logic                 AWVALID,
    input  logic                 AWREADY,
    // write data channel
    output logic [DBUS_SIZE-1:0] WDATA,
    output logic                 WVALID,
    input  logic                 WREADY,
    // write response channel
    input  logic [1:0]           BRESP,
    input  logic                 BVALID,
    output logic                 BREADY,
    // read address channel
    output logic [ABUS_SIZE-1:0] ARADDR,
    output logic                 ARVALID,
    input  logic                 ARREADY,
    // read data channel
    input  logic [DBUS_SIZE-1:0] RDATA,
    input  logic [1:0]           RRESP,
    input  logic                 RVALID,
    output logic                 RREADY,
    // response side
    output logic                 RSP_VALID,
    input  logic                 RSP_READY,
    output logic                 RSP_WRITE,
    output logic [DBUS_SIZE-1:0] RSP_RDATA,
    output logic [1:0]           RSP_RESP,
    output logic [ECNT_SIZE-1:0] ERR_COUNT
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RSP
    } state_t;

    state_t               state_q;
    logic                 cmd_ready_q;
    logic [ABUS_SIZE-1:0] awaddr_q;
    logic                 awvalid_q;
    logic [DBUS_SIZE-1:0] wdata_q;
    logic                 wvalid_q;
    logic                 bready_q;
    logic [ABUS_SIZE-1:0] araddr_q;
    logic                 arvalid_q;
    logic                 rready_q;
    logic                 aw_done_q;
    logic                 w_done_q;
    logic                 rsp_valid_q;
    logic                 rsp_write_q;
    logic [DBUS_SIZE-1:0] rsp_rdata_q;
    logic [1:0]           rsp_resp_q;
    logic [ECNT_SIZE-1:0] err_cnt_q;
    logic [ECNT_SIZE-1:0] err_cnt_d;

    logic aw_fire, w_fire, aw_done_d, w_done_d;

    // Handshakes only count against our own registered valids, so a READY
    // raised early by the subordinate never completes anything.
    assign aw_fire   = awvalid_q && AWREADY;
    assign w_fire    = wvalid_q && WREADY;
    assign aw_done_d = aw_done_q || aw_fire;
    assign w_done_d  = w_done_q || w_fire;

    // Saturating error counter increment (applied only on error responses).
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_cnt_q != {ECNT_SIZE{1'b1}})
            err_cnt_d = err_cnt_q + {{(ECNT_SIZE-1){1'b0}}, 1'b1};
    end

    // Transaction FSM; every output is a register written here.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            awaddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wdata_q     <= '0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
            err_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_ready_q && CMD_VALID) begin
                        cmd_ready_q <= 1'b0;
                        if (CMD_WRITE) begin
                            awaddr_q  <= CMD_ADDR;
                            wdata_q   <= CMD_WDATA;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                            state_q   <= WR_REQ;
                        end else begin
                            araddr_q  <= CMD_ADDR;
                            arvalid_q <= 1'b1;
                            state_q   <= RD_REQ;
                        end
                    end else begin
                        // first cycle after reset raises CMD_READY
                        cmd_ready_q <= 1'b1;
                    end
                end
                WR_REQ: begin
                    // AW and W retire independently, in either order
                    if (aw_fire) awvalid_q <= 1'b0;
                    if (w_fire)  wvalid_q  <= 1'b0;
                    aw_done_q <= aw_done_d;
                    w_done_q  <= w_done_d;
                    if (aw_done_d && w_done_d) begin
                        bready_q <= 1'b1;
                        state_q  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (BVALID && bready_q) begin
                        bready_q    <= 1'b0;
                        rsp_resp_q  <= BRESP;
                        rsp_write_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_valid_q <= 1'b1;
                        if (BRESP[1]) err_cnt_q <= err_cnt_d;
                        state_q     <= RSP;
                    end
                end
                RD_REQ: begin
                    if (arvalid_q && ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (RVALID && rready_q) begin
                        rready_q    <= 1'b0;
                        rsp_resp_q  <= RRESP;
                        rsp_write_q <= 1'b0;
                        rsp_rdata_q <= RDATA;
                        rsp_valid_q <= 1'b1;
                        if (RRESP[1]) err_cnt_q <= err_cnt_d;
                        state_q     <= RSP;
                    end
                end
                RSP: begin
                    if (RSP_READY) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign CMD_READY = cmd_ready_q;
    assign AWADDR    = awaddr_q;
    assign AWVALID   = awvalid_q;
    assign WDATA     = wdata_q;
    assign WVALID    = wvalid_q;
    assign BREADY    = bready_q;
    assign ARADDR    = araddr_q;
    assign ARVALID   = arvalid_q;
    assign RREADY    = rready_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_WRITE = rsp_write_q;
    assign RSP_RDATA = rsp_rdata_q;
    assign RSP_RESP  = rsp_resp_q;
    assign ERR_COUNT = err_cnt_q;

endmodule
